// File: rtl/rotating_square_pkg.sv
// Shared types and segment patterns for the rotating-square display generator.
// Segment bytes are {dp,g,f,e,d,c,b,a}, active-low.
package rotating_square_pkg;

  typedef logic [7:0] sseg_t;

  localparam sseg_t SEG_UPPER = 8'h9C;  // a,b,f,g lit
  localparam sseg_t SEG_LOWER = 8'hA3;  // c,d,e,g lit
  localparam sseg_t SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    PatBlank,
    PatUpper,
    PatLower
  } pat_e;

  function automatic sseg_t pat_to_seg(pat_e pat);
    case (pat)
      PatUpper: return SEG_UPPER;
      PatLower: return SEG_LOWER;
      default:  return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/rotating_square_gen_if.sv
// Control and display bundle of the rotating-square generator.
// The master side is the switch/board logic, the slave side is the generator.
interface rotating_square_gen_if
  import rotating_square_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8
);
  localparam int unsigned PosW = $clog2(2 * NUM_DIGITS);

  logic                  en;
  logic                  cw;
  logic [1:0]            spd;
  logic [NUM_DIGITS-1:0] an;
  sseg_t                 sseg;
  logic [PosW-1:0]       pos;
  logic                  step;
  logic                  wrap;

  modport master (
    output en, cw, spd,
    input  an, sseg, pos, step, wrap
  );

  modport slave (
    input  en, cw, spd,
    output an, sseg, pos, step, wrap
  );

endinterface

// File: rtl/sseg_scan_mux.sv
// Multiplexed 7-seg driver: free-running scan counter selects one digit at a time
// and registers the active-low enable and segment byte for it.
module sseg_scan_mux
  import rotating_square_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SCAN_W     = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  pat_e [NUM_DIGITS-1:0] pat_sel,
  output logic [NUM_DIGITS-1:0] an,
  output sseg_t                 sseg
);

  localparam int unsigned DigW = $clog2(NUM_DIGITS);
  localparam logic [DigW-1:0] DigLast = DigW'(NUM_DIGITS - 1);

  logic [SCAN_W-1:0]     scan_q;
  logic [DigW-1:0]       dig_q;
  logic [NUM_DIGITS-1:0] an_d;
  sseg_t                 sseg_d;

  always_comb begin
    an_d        = '1;
    an_d[dig_q] = 1'b0;
    sseg_d      = pat_to_seg(pat_sel[dig_q]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_q <= '0;
      dig_q  <= '0;
      an     <= '1;
      sseg   <= SEG_BLANK;
    end else begin
      scan_q <= scan_q + 1'b1;
      if (&scan_q) begin
        dig_q <= (dig_q == DigLast) ? '0 : dig_q + 1'b1;
      end
      an   <= an_d;
      sseg <= sseg_d;
    end
  end

endmodule

// File: rtl/rotating_square_gen.sv
// Rotating square around an N-digit 7-seg bank: prescaler, position counter with
// step/wrap strobes, and per-digit pattern decode feeding the scan mux.
module rotating_square_gen
  import rotating_square_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned TICK_W     = 27,
  parameter int unsigned SCAN_W     = 17
) (
  input logic                 clk,
  input logic                 reset,
  rotating_square_gen_if.slave bus
);

  localparam int unsigned PosW = $clog2(2 * NUM_DIGITS);
  localparam logic [PosW-1:0] PosLast = PosW'(2 * NUM_DIGITS - 1);

  logic [TICK_W-1:0]     presc_q;
  logic [TICK_W-1:0]     tick_mask;
  logic                  tick;
  logic [PosW-1:0]       pos_q, pos_d;
  logic                  step_q;
  logic                  wrap_q, wrap_d;
  pat_e [NUM_DIGITS-1:0] pat_sel;
  logic [NUM_DIGITS-1:0] an_w;
  sseg_t                 sseg_w;

  // Faster speeds look at fewer low prescaler bits, so the period halves per step.
  always_comb begin
    tick_mask = {TICK_W{1'b1}} >> bus.spd;
    tick      = bus.en & ((presc_q & tick_mask) == tick_mask);
  end

  always_comb begin
    pos_d  = pos_q;
    wrap_d = 1'b0;
    if (tick) begin
      if (bus.cw) begin
        if (pos_q == PosLast) begin
          pos_d  = '0;
          wrap_d = 1'b1;
        end else begin
          pos_d = pos_q + 1'b1;
        end
      end else begin
        if (pos_q == '0) begin
          pos_d  = PosLast;
          wrap_d = 1'b1;
        end else begin
          pos_d = pos_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      pos_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      if (bus.en) begin
        presc_q <= presc_q + 1'b1;
      end
      pos_q  <= pos_d;
      step_q <= tick;
      wrap_q <= wrap_d;
    end
  end

  // Top half runs from the leftmost digit rightwards; bottom half returns from digit 0.
  always_comb begin
    int unsigned p;
    p = 32'(pos_q);
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      pat_sel[d] = PatBlank;
      if (p < NUM_DIGITS) begin
        if (d == NUM_DIGITS - 1 - p) pat_sel[d] = PatUpper;
      end else if (d == p - NUM_DIGITS) begin
        pat_sel[d] = PatLower;
      end
    end
  end

  sseg_scan_mux #(
    .NUM_DIGITS(NUM_DIGITS),
    .SCAN_W    (SCAN_W)
  ) u_scan_mux (
    .clk    (clk),
    .reset  (reset),
    .pat_sel(pat_sel),
    .an     (an_w),
    .sseg   (sseg_w)
  );

  assign bus.an   = an_w;
  assign bus.sseg = sseg_w;
  assign bus.pos  = pos_q;
  assign bus.step = step_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_rotating_square_gen.sv
// Bench for rotating_square_gen (4 digits, 6-bit prescaler, 2-bit scan): cycle
// scoreboard against a behavioural model plus directed vector table and corner sequences.
module tb_rotating_square_gen;

  localparam int ND = 4;
  localparam int TW = 6;
  localparam int SW = 2;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] sseg;
    logic [2:0] pos;
    logic       step;
    logic       wrap;
  } exp_t;

  typedef struct {
    int         pos;
    int         wrap;
    int         digit;
    logic [7:0] seg;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc_cnt = 0;

  int   m_presc, m_pos, m_dig, m_scan;
  exp_t sb_q[$];

  rotating_square_gen_if #(.NUM_DIGITS(ND)) bus ();

  rotating_square_gen #(
    .NUM_DIGITS(ND),
    .TICK_W    (TW),
    .SCAN_W    (SW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Behavioural model: advance one clock using the inputs present before the edge.
  task automatic model_next(output exp_t e);
    int   period, sq;
    logic tick;
    if (reset) begin
      m_presc = 0; m_pos = 0; m_dig = 0; m_scan = 0;
      e = '{an: 4'hF, sseg: 8'hFF, pos: 3'd0, step: 1'b0, wrap: 1'b0};
    end else begin
      period = 1 << (TW - int'(bus.spd));
      tick   = bus.en && ((m_presc % period) == period - 1);
      e.an   = 4'hF;
      e.an[m_dig] = 1'b0;
      sq     = (m_pos < ND) ? ND - 1 - m_pos : m_pos - ND;
      e.sseg = (sq != m_dig) ? 8'hFF : ((m_pos < ND) ? 8'h9C : 8'hA3);
      e.step = tick;
      e.wrap = tick && ((bus.cw && m_pos == 2 * ND - 1) || (!bus.cw && m_pos == 0));
      if (tick) m_pos = bus.cw ? (m_pos + 1) % (2 * ND) : (m_pos + 2 * ND - 1) % (2 * ND);
      e.pos = 3'(m_pos);
      if (bus.en) m_presc = (m_presc + 1) % (1 << TW);
      if (m_scan == (1 << SW) - 1) m_dig = (m_dig + 1) % ND;
      m_scan = (m_scan + 1) % (1 << SW);
    end
  endtask

  task automatic cyc();
    exp_t e, a;
    model_next(e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc_cnt++;
    e = sb_q.pop_front();
    a = {bus.an, bus.sseg, bus.pos, bus.step, bus.wrap};
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL scoreboard cyc=%0d got an=%h sseg=%h pos=%0d step=%b wrap=%b expected an=%h sseg=%h pos=%0d step=%b wrap=%b",
               cyc_cnt, a.an, a.sseg, a.pos, a.step, a.wrap, e.an, e.sseg, e.pos, e.step, e.wrap);
    end
  endtask

  task automatic wait_step(input int limit, output int n);
    bit got = 0;
    n = 0;
    while (!got && n < limit) begin
      cyc();
      n++;
      got = (bus.step === 1'b1);
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL step_timeout: got no step in %0d cycles, expected one", limit);
    end
  endtask

  task automatic wait_an(input logic [3:0] exp_an, input int limit);
    int  n = 0;
    bit  got = 0;
    while (!got && n < limit) begin
      cyc();
      n++;
      got = (bus.an === exp_an);
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL an_timeout: got an=%h, expected %h within %0d cycles", bus.an, exp_an, limit);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[8];
    int   n, prev, p0, total;

    tbl[0] = '{1, 0, 2, 8'h9C};
    tbl[1] = '{2, 0, 1, 8'h9C};
    tbl[2] = '{3, 0, 0, 8'h9C};
    tbl[3] = '{4, 0, 0, 8'hA3};
    tbl[4] = '{5, 0, 1, 8'hA3};
    tbl[5] = '{6, 0, 2, 8'hA3};
    tbl[6] = '{7, 0, 3, 8'hA3};
    tbl[7] = '{0, 1, 3, 8'h9C};

    bus.en  = 1'b0;
    bus.cw  = 1'b1;
    bus.spd = 2'd0;

    // Reset held three cycles
    reset = 1'b1;
    repeat (3) cyc();
    check("reset_an", int'(bus.an), 'hF);
    check("reset_sseg", int'(bus.sseg), 'hFF);
    check("reset_pos", int'(bus.pos), 0);
    check("reset_step", int'(bus.step), 0);
    reset = 1'b0;
    wait_an(4'h7, (1 << SW) * ND + 1);
    check("first_upper_seg", int'(bus.sseg), 'h9C);

    // Clockwise lap at the slowest speed
    bus.en = 1'b1;
    prev = cyc_cnt;
    for (int i = 0; i < 8; i++) begin
      wait_step(200, n);
      check($sformatf("lap_pos[%0d]", i), int'(bus.pos), tbl[i].pos);
      check($sformatf("lap_wrap[%0d]", i), int'(bus.wrap), tbl[i].wrap);
      check($sformatf("lap_period[%0d]", i), cyc_cnt - prev, 64);
      prev = cyc_cnt;
      wait_an(~(4'(1) << tbl[i].digit), 20);
      check($sformatf("lap_seg[%0d]", i), int'(bus.sseg), int'(tbl[i].seg));
    end

    // Counter-clockwise from pos 0 wraps to the last position
    bus.cw = 1'b0;
    wait_step(200, n);
    check("ccw_pos", int'(bus.pos), 7);
    check("ccw_wrap", int'(bus.wrap), 1);
    wait_an(4'h7, 20);
    check("ccw_seg", int'(bus.sseg), 'hA3);

    // Speed select: first period after a change may be irregular
    bus.spd = 2'd3;
    wait_step(100, n);
    for (int i = 0; i < 4; i++) begin
      wait_step(100, n);
      check($sformatf("spd3_period[%0d]", i), n, 8);
    end
    bus.spd = 2'd2;
    wait_step(100, n);
    for (int i = 0; i < 4; i++) begin
      wait_step(100, n);
      check($sformatf("spd2_period[%0d]", i), n, 16);
    end

    // Pause for ten cycles mid-period
    p0 = int'(bus.pos);
    repeat (5) cyc();
    bus.en = 1'b0;
    total = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      total += int'(bus.step);
    end
    check("pause_no_step", total, 0);
    check("pause_pos_held", int'(bus.pos), p0);
    bus.en = 1'b1;
    wait_step(100, n);
    check("pause_delayed_period", 15 + n, 26);

    // Reset landing on a tick cycle
    bus.spd = 2'd3;
    wait_step(100, n);
    repeat (7) cyc();
    reset = 1'b1;
    cyc();
    check("tick_reset_pos", int'(bus.pos), 0);
    check("tick_reset_step", int'(bus.step), 0);
    check("tick_reset_wrap", int'(bus.wrap), 0);
    check("tick_reset_an", int'(bus.an), 'hF);
    reset = 1'b0;
    cyc();
    check("post_reset_an", int'(bus.an), 'hE);
    check("post_reset_sseg", int'(bus.sseg), 'hFF);
    repeat (4) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
